bram_stream_reader: RTL and testbench
=====================================

Name: bram_stream_reader

Overview:
- Read-side consumer for the dual-port frame/scene BRAM with registered output (2-cycle read latency).
- On `start_in`, fetches `count_in` consecutive words starting at `base_addr_in` through one BRAM port.
- Presents the words as a valid/ready stream to the downstream pixel/ray pipeline.
- Absorbs the BRAM read latency and downstream backpressure with a credit-gated internal FIFO, so no read is lost or duplicated.

Parameters:
- RAM_WIDTH, 18: data word width; must match the BRAM.
- RAM_DEPTH, 1024: BRAM entries. AW = clogb2(RAM_DEPTH-1), the BRAM address-width function.
- READ_LATENCY, 2: cycles from address/enable presented to data valid on `data_in`; 2 for HIGH_PERFORMANCE, 1 for LOW_LATENCY.
- FIFO_DEPTH, 4: output FIFO entries; must be ≥ READ_LATENCY+1 and a power of two.

Ports:
- clk_in  input  1  system clock; also clocks the BRAM port.
- rst_in  input  1  reset, synchronous, active-high.
- start_in  input  1  begin a burst; sampled only in IDLE.
- base_addr_in  input  AW  first address, captured on accepted start.
- count_in  input  AW+1  words to read, captured on accepted start.
- busy_out  output  1  high from accepted start until `done_out`.
- done_out  output  1  one-cycle pulse at burst completion.
- addr_out  output  AW  BRAM port address.
- en_out  output  1  BRAM port enable.
- regce_out  output  1  BRAM output-register enable.
- data_in  input  RAM_WIDTH  BRAM port read data.
- data_out  output  RAM_WIDTH  stream data (FIFO head).
- valid_out  output  1  stream valid.
- ready_in  input  1  downstream ready.
- last_out  output  1  qualifies the final word of the burst; valid only with `valid_out`.

Behaviour:
- Reset values: `busy_out`, `done_out`, `en_out`, `regce_out`, `valid_out`, `last_out` = 0; `addr_out` = 0; `data_out` = 0.
- Reset clears the FIFO, credit counter, latency tag pipeline and state.
- Reset mid-burst aborts the burst: no `done_out`, and no stale word appears after reset.
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - `start_in` = 1 captures base and count, with count clamped to RAM_DEPTH.
  - Count 0 → DONE. Otherwise → FETCH.
  - `start_in` outside IDLE is ignored.
- FETCH:
  - A read issues in a cycle iff `issued < count` and `outstanding + fifo_occupancy < FIFO_DEPTH`.
  - On issue: `addr_out` = current address, with a 1-bit tag (last flag) entering a READ_LATENCY-deep valid/tag shift register.
  - Address increments after each issue and wraps from RAM_DEPTH-1 to 0 (explicit compare; non-power-of-2 depth supported).
  - After the final issue → DRAIN.
- DRAIN: when the FIFO is empty, the tag pipeline is empty and the last word has been handshaken → DONE.
- DONE: `done_out` = 1 for one cycle, `busy_out` drops in the same cycle; → IDLE.
- `en_out` = `regce_out` = 1 whenever state is FETCH or DRAIN; 0 otherwise.
  - The BRAM pipeline advances every cycle and is never stalled.
  - Credit gating guarantees FIFO space for every in-flight word.
- A word is written into the FIFO when the tag pipeline output is valid, capturing `data_in` and the tag's last flag.
- Stream rules:
  - `valid_out` = FIFO non-empty; transfer when `valid_out && ready_in`.
  - `data_out` and `last_out` hold stable while `valid_out && !ready_in`.
- Simultaneous FIFO write and read in one cycle is supported; occupancy is unchanged.
- Full-rate throughput: with `ready_in` held 1, one word per cycle after an initial READ_LATENCY+1 cycle fill.
  - First `valid_out` appears READ_LATENCY+1 cycles after the first issue.
  - The FIFO is a registered write; `data_out` comes from the FIFO head register.
- `outstanding` counts in-flight reads: +1 on issue, −1 on FIFO write.
- `fifo_occupancy` counts FIFO entries: +1 on write, −1 on handshake.

Optional Feature:
- Macro: BRAM_STREAM_READER_STALL_COUNT_EN.
- Defined:
  - Adds output `stall_cycles_out` [15:0], counting cycles with `valid_out && !ready_in` during a burst.
  - Saturates at 16'hFFFF.
  - Cleared to 0 on accepted start and on reset; holds its value after `done_out`.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Base 0x010, count 8, `ready_in` held 1, BRAM preloaded with mem[i] = i:
  - Words 0x010..0x017 appear on 8 consecutive cycles.
  - First `valid_out` 3 cycles after the first `en_out` issue.
  - `last_out` is high only on 0x017; `done_out` pulses exactly once.
- Base 1020, count 8, RAM_DEPTH 1024: addresses 1020, 1021, 1022, 1023, 0, 1, 2, 3 are read in order; data matches.
- Count 16, `ready_in` toggled 1,0,0,1 repeating:
  - All 16 words delivered once, in order.
  - No more than 4 words are ever in flight or buffered.
  - `data_out` is stable across stall cycles.
- Count 0: `done_out` pulses 1 cycle after start; `valid_out` is never asserted; no `en_out`.
- Reset asserted mid-burst after 5 words of 32:
  - All outputs return to reset values the next cycle and no further `valid_out` appears.
  - A new start of count 2 then completes normally.
- With BRAM_STREAM_READER_STALL_COUNT_EN, count 4, `ready_in` held 0 for 10 cycles after the first valid, then 1: `stall_cycles_out` = 10 at `done_out`.

Source files
------------

// File: rtl/bram_stream_reader.sv
// Burst reader: fetches count words from a registered-output BRAM and streams them out
// through a credit-gated FIFO. Optional stall counter: BRAM_STREAM_READER_STALL_COUNT_EN.
module bram_stream_reader #(
  parameter int RAM_WIDTH    = 18,
  parameter int RAM_DEPTH    = 1024,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4,
  // Same value as the BRAM's clogb2(RAM_DEPTH-1) address width.
  localparam int AW          = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic [AW-1:0]        base_addr_in,
  input  logic [AW:0]          count_in,
  output logic                 busy_out,
  output logic                 done_out,
  output logic [AW-1:0]        addr_out,
  output logic                 en_out,
  output logic                 regce_out,
  input  logic [RAM_WIDTH-1:0] data_in,
  output logic [RAM_WIDTH-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_in,
`ifdef BRAM_STREAM_READER_STALL_COUNT_EN
  output logic [15:0]          stall_cycles_out,
`endif
  output logic                 last_out
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = PW + 1;
  localparam int SW = PW + 2;
  localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_DEPTH - 1);
  localparam logic [AW:0]   DEPTH_C   = CW'(RAM_DEPTH);
  localparam logic [AW:0]   CNT_ONE   = CW'(1);
  localparam logic [PW:0]   OCC_ONE   = OW'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW+1:0] FD_C      = SW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                  state_q;
  logic                    active_q;
  logic                    done_q;
  logic [AW-1:0]           addr_q;
  logic [AW:0]             cnt_q;
  logic [AW:0]             issued_q;
  logic [PW:0]             outst_q;
  logic [PW:0]             occ_q;
  logic [PW-1:0]           wr_ptr_q;
  logic [PW-1:0]           rd_ptr_q;
  logic [READ_LATENCY-1:0] vld_p;
  logic [READ_LATENCY-1:0] last_p;
  logic [RAM_WIDTH-1:0]    fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   fifo_last;

  logic [PW+1:0] credit_used;
  logic          issue;
  logic          last_issue;
  logic          fifo_wr;
  logic          fifo_rd;

  // Credit covers both in-flight reads and buffered words, so the BRAM never needs stalling.
  assign credit_used = {1'b0, outst_q} + {1'b0, occ_q};
  assign issue       = (state_q == FETCH) && (issued_q < cnt_q) && (credit_used < FD_C);
  assign last_issue  = (issued_q + CNT_ONE) == cnt_q;
  assign fifo_wr     = vld_p[READ_LATENCY-1];
  assign fifo_rd     = valid_out && ready_in;

  assign valid_out = (occ_q != '0);
  assign data_out  = valid_out ? fifo_data[rd_ptr_q] : '0;
  assign last_out  = valid_out & fifo_last[rd_ptr_q];
  assign busy_out  = active_q;
  assign en_out    = active_q;
  assign regce_out = active_q;
  assign done_out  = done_q;
  assign addr_out  = addr_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      addr_q   <= '0;
      cnt_q    <= '0;
      issued_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_in) begin
            addr_q   <= base_addr_in;
            cnt_q    <= (count_in > DEPTH_C) ? DEPTH_C : count_in;
            issued_q <= '0;
            if (count_in == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q  <= FETCH;
              active_q <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (issue) begin
            addr_q   <= (addr_q == LAST_ADDR) ? '0 : addr_q + AW'(1);
            issued_q <= issued_q + CNT_ONE;
            if (last_issue) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if ((occ_q == '0) && (vld_p == '0)) begin
            state_q  <= DONE;
            active_q <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stage p0..pN: tag pipeline mirrors the BRAM read latency
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= issue;
      for (int i = 1; i < READ_LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
    last_p[0] <= issue && last_issue;
    for (int i = 1; i < READ_LATENCY; i++) last_p[i] <= last_p[i-1];
  end

  // FIFO stage: captures data_in when the tag emerges
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      outst_q  <= '0;
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      case ({issue, fifo_wr})
        2'b10:   outst_q <= outst_q + OCC_ONE;
        2'b01:   outst_q <= outst_q - OCC_ONE;
        default: outst_q <= outst_q;
      endcase
      case ({fifo_wr, fifo_rd})
        2'b10:   occ_q <= occ_q + OCC_ONE;
        2'b01:   occ_q <= occ_q - OCC_ONE;
        default: occ_q <= occ_q;
      endcase
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (fifo_rd) rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_in) begin
    if (fifo_wr) begin
      fifo_data[wr_ptr_q] <= data_in;
      fifo_last[wr_ptr_q] <= last_p[READ_LATENCY-1];
    end
  end

`ifdef BRAM_STREAM_READER_STALL_COUNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stall_q <= '0;
    end else if ((state_q == IDLE) && start_in) begin
      stall_q <= '0;
    end else if (active_q && valid_out && !ready_in && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles_out = stall_q;
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Randomised scoreboard bench for bram_stream_reader with a behavioural 2-cycle BRAM model.
module tb_bram_stream_reader;
  localparam int W     = 18;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int RL    = 2;
  localparam int FD    = 4;

  logic          clk;
  logic          rst_in;
  logic          start_in;
  logic [AW-1:0] base_addr_in;
  logic [AW:0]   count_in;
  logic          busy_out;
  logic          done_out;
  logic [AW-1:0] addr_out;
  logic          en_out;
  logic          regce_out;
  logic [W-1:0]  data_in;
  logic [W-1:0]  data_out;
  logic          valid_out;
  logic          ready_in;
  logic          last_out;
`ifdef BRAM_STREAM_READER_STALL_COUNT_EN
  logic [15:0]   stall_cycles_out;
`endif

  bram_stream_reader #(
    .RAM_WIDTH(W), .RAM_DEPTH(DEPTH), .READ_LATENCY(RL), .FIFO_DEPTH(FD)
  ) dut (
    .clk_in(clk), .rst_in(rst_in), .start_in(start_in),
    .base_addr_in(base_addr_in), .count_in(count_in),
    .busy_out(busy_out), .done_out(done_out), .addr_out(addr_out),
    .en_out(en_out), .regce_out(regce_out), .data_in(data_in),
    .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
`ifdef BRAM_STREAM_READER_STALL_COUNT_EN
    .stall_cycles_out(stall_cycles_out),
`endif
    .last_out(last_out)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Behavioural BRAM: array read then output register.
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] ram_q;
  always @(posedge clk) begin
    if (en_out) ram_q <= mem[addr_out];
    if (regce_out) data_in <= ram_q;
  end

  int total = 0;
  int bad   = 0;
  logic [W:0] sb_q [$];

  int cyc = 0;
  int en_cnt, vld_cnt, hs_cnt, done_cnt, stall_cnt, last_cnt;
  int first_en, first_vld, first_hs, last_hs;
  int issued_seen = 0;
  int hs_total    = 0;
  int rdy_mode    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    en_cnt = 0; vld_cnt = 0; hs_cnt = 0; done_cnt = 0; stall_cnt = 0; last_cnt = 0;
    first_en = -1; first_vld = -1; first_hs = -1; last_hs = -1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Ready generator: 0 hold high, 1 pattern 1,0,0,1, 2 hold low, 3 random.
  initial begin
    int ph;
    ph = 0;
    ready_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: ready_in = 1'b1;
        1: begin ready_in = (ph == 0) || (ph == 3); ph = (ph + 1) % 4; end
        2: ready_in = 1'b0;
        default: ready_in = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks stream rules.
  initial begin
    logic          prev_vld, prev_rdy, prev_last, prev_busy;
    logic [W-1:0]  prev_data;
    logic [AW-1:0] prev_addr;
    logic [W:0]    exp;
    int            inflight;
    prev_vld = 0; prev_rdy = 0; prev_last = 0; prev_busy = 0; prev_data = '0; prev_addr = '0;
    forever begin
      @(negedge clk);
      if (rst_in) begin
        prev_vld = 0; prev_busy = 0; issued_seen = 0; hs_total = 0;
      end else begin
        if (busy_out && prev_busy && (addr_out != prev_addr)) issued_seen++;
        if (busy_out) begin
          inflight = issued_seen - hs_total;
          total++;
          if (inflight > FD) begin
            bad++;
            $display("FAIL inflight_limit: got %0d, required <= %0d", inflight, FD);
          end
        end
        if (en_out) begin en_cnt++; if (first_en < 0) first_en = cyc; end
        if (valid_out) begin vld_cnt++; if (first_vld < 0) first_vld = cyc; end
        if (prev_vld && !prev_rdy) begin
          chk("hold_valid", valid_out, 1);
          chk("hold_data", data_out, prev_data);
          chk("hold_last", last_out, prev_last);
        end
        if (valid_out && !ready_in) stall_cnt++;
        if (valid_out && ready_in) begin
          if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word: got %0h, required no word", data_out);
          end else begin
            exp = sb_q.pop_front();
            chk("data", data_out, exp[W-1:0]);
            chk("last", last_out, exp[W]);
          end
          if (last_out) last_cnt++;
          hs_cnt++;
          hs_total++;
          if (first_hs < 0) first_hs = cyc;
          last_hs = cyc;
        end
        if (done_out) begin
          done_cnt++;
`ifdef BRAM_STREAM_READER_STALL_COUNT_EN
          chk("stall_cycles", stall_cycles_out, stall_cnt);
`endif
        end
        prev_vld  = valid_out;
        prev_rdy  = ready_in;
        prev_data = data_out;
        prev_last = last_out;
        prev_busy = busy_out;
      end
      prev_addr = addr_out;
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy_out, 0);
    chk({tag, "_done"}, done_out, 0);
    chk({tag, "_en"}, en_out, 0);
    chk({tag, "_regce"}, regce_out, 0);
    chk({tag, "_valid"}, valid_out, 0);
    chk({tag, "_last"}, last_out, 0);
    chk({tag, "_addr"}, addr_out, 0);
    chk({tag, "_data"}, data_out, 0);
  endtask

  task automatic start_burst(input int base, input int cnt);
    int n;
    @(posedge clk);
    #1;
    n = (cnt > DEPTH) ? DEPTH : cnt;
    for (int i = 0; i < n; i++) sb_q.push_back({(i == n - 1), mem[(base + i) % DEPTH]});
    clear_stats();
    base_addr_in = base[AW-1:0];
    count_in     = cnt[AW:0];
    start_in     = 1'b1;
    @(posedge clk);
    #1;
    start_in = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_out) begin seen = 1; break; end
    end
    chk("done_seen", seen, 1);
    if (seen) chk("busy_at_done", busy_out, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic end_checks(input int n);
    chk("word_count", hs_cnt, n);
    chk("done_pulses", done_cnt, 1);
    chk("last_count", last_cnt, (n > 0) ? 1 : 0);
    chk("sb_empty", sb_q.size(), 0);
  endtask

  initial begin
    int snap_vld, base, cnt, modes[3];
    bit ok;
    modes[0] = 0; modes[1] = 1; modes[2] = 3;
    rst_in = 1; start_in = 0; base_addr_in = '0; count_in = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = W'(i);
    clear_stats();
    repeat (5) @(posedge clk);
    #1 rst_in = 0;
    @(negedge clk);
    check_idle_outputs("reset");

    // Full-rate burst, latency and contiguity.
    start_burst(16, 8);
    wait_done(100);
    end_checks(8);
    chk("first_valid_latency", first_vld - first_en, RL + 1);
    chk("contiguous_words", last_hs - first_hs, 7);

    // Address wrap at the top of the BRAM.
    start_burst(1020, 8);
    wait_done(100);
    end_checks(8);

    // Backpressure pattern plus an ignored start mid-burst.
    rdy_mode = 1;
    start_burst(100, 16);
    repeat (3) @(posedge clk);
    #1 start_in = 1; base_addr_in = '0; count_in = 11'd5;
    @(posedge clk);
    #1 start_in = 0;
    wait_done(300);
    end_checks(16);

    // Zero-length burst.
    rdy_mode = 0;
    start_burst(5, 0);
    @(negedge clk);
    chk("zero_done_timing", done_out, 1);
    repeat (3) @(negedge clk);
    chk("zero_done_pulses", done_cnt, 1);
    chk("zero_no_en", en_cnt, 0);
    chk("zero_no_valid", vld_cnt, 0);

    // Reset in the middle of a burst, then a fresh burst.
    start_burst(200, 32);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (hs_cnt >= 5) begin ok = 1; break; end
    end
    chk("reach_5_words", ok, 1);
    #1 rst_in = 1;
    @(posedge clk);
    #1 rst_in = 0;
    sb_q.delete();
    snap_vld = vld_cnt;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    repeat (10) @(negedge clk);
    chk("no_valid_after_reset", vld_cnt - snap_vld, 0);
    chk("no_done_after_reset", done_cnt, 0);
    start_burst(40, 2);
    wait_done(100);
    end_checks(2);

    // Downstream held off for 10 cycles after the first word.
    rdy_mode = 2;
    @(negedge clk);
    start_burst(300, 4);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (valid_out) begin ok = 1; break; end
    end
    chk("stall_first_valid", ok, 1);
    repeat (9) @(negedge clk);
    rdy_mode = 0;
    wait_done(100);
    end_checks(4);
    chk("bench_stall_count", stall_cnt, 10);
`ifdef BRAM_STREAM_READER_STALL_COUNT_EN
    chk("stall_hold_after_done", stall_cycles_out, 10);
`endif

    // Random contents, bases, lengths and backpressure.
    for (int i = 0; i < DEPTH; i++) mem[i] = W'($urandom);
    for (int k = 0; k < 8; k++) begin
      rdy_mode = modes[$urandom_range(0, 2)];
      base = $urandom_range(0, DEPTH - 1);
      cnt  = $urandom_range(1, 40);
      start_burst(base, cnt);
      wait_done(10 * cnt + 100);
      end_checks(cnt);
    end

    // Oversized count clamps to the BRAM depth.
    rdy_mode = 0;
    start_burst($urandom_range(0, DEPTH - 1), 1100);
    wait_done(1300);
    end_checks(DEPTH);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
